// File: rtl/syndrome_calc.sv
// BCH syndrome calculator over GF(2^10): streams 8-bit beats and produces S1..S8 = r(alpha^j).
// Define SYN_SQUARE_EN to accumulate only the odd syndromes and derive the even ones by squaring.
module syndrome_calc #(
    parameter int unsigned MAX_BITS = 1023
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    input  logic       i_last,
    input  logic [2:0] i_last_cnt,
    output logic [9:0] o_S1,
    output logic [9:0] o_S2,
    output logic [9:0] o_S3,
    output logic [9:0] o_S4,
    output logic [9:0] o_S5,
    output logic [9:0] o_S6,
    output logic [9:0] o_S7,
    output logic [9:0] o_S8,
    output logic       o_valid,
    output logic       o_err_free,
    output logic       o_len_err,
    output logic       o_busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    function automatic logic [9:0] mul_alpha(input logic [9:0] x);
        return {x[8:0], 1'b0} ^ (x[9] ? 10'h009 : 10'h000);
    endfunction

    function automatic logic [9:0] mul_alpha_pow(input logic [9:0] x, input int p);
        logic [9:0] r;
        r = x;
        for (int n = 0; n < p; n++) r = mul_alpha(r);
        return r;
    endfunction

`ifdef SYN_SQUARE_EN
    localparam int NumAcc = 4;

    // Accumulator i holds S_(2i+1).
    function automatic int acc_pow(input int i);
        return 2 * i + 1;
    endfunction

    function automatic logic [9:0] gf_sq(input logic [9:0] x);
        logic [9:0] r;
        logic [9:0] p;
        r = '0;
        p = 10'h001;
        for (int i = 0; i < 10; i++) begin
            if (x[i]) r = r ^ p;
            p = mul_alpha(mul_alpha(p));
        end
        return r;
    endfunction
`else
    localparam int NumAcc = 8;

    function automatic int acc_pow(input int i);
        return i + 1;
    endfunction
`endif

    state_e                     state_q, state_d;
    logic [NumAcc-1:0][9:0]     acc_q, acc_d, acc_base, acc_step;
    logic [10:0]                cnt_q, cnt_d, cnt_base;
    logic [11:0]                cnt_sum;
    logic [3:0]                 nbits;
    logic                       valid_q, valid_d;
    logic                       pend_q, pend_d;
    logic                       err_free_q, err_free_d;
    logic                       len_err_q, len_err_d;
    logic                       beat_acc, done_now;

    assign beat_acc = i_data_valid && (i_start || state_q == StAcc);
    assign done_now = beat_acc && i_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_start) begin
            state_d = done_now ? StDone : StAcc;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StAcc:   state_d = done_now ? StDone : StAcc;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        o_busy = (state_q == StAcc);
    end

    always_comb begin
        nbits    = (i_last && i_last_cnt != 3'd0) ? {1'b0, i_last_cnt} : 4'd8;
        acc_base = i_start ? '0 : acc_q;
        acc_step = acc_base;
        // Horner steps MSB first; on the last beat only the top nbits bits are stepped.
        for (int b = 7; b >= 0; b--) begin
            if (8 - b <= int'(nbits)) begin
                for (int i = 0; i < NumAcc; i++) begin
                    acc_step[i] = mul_alpha_pow(acc_step[i], acc_pow(i)) ^ {9'b0, i_data[b]};
                end
            end
        end
        acc_d = beat_acc ? acc_step : acc_base;

        cnt_base = i_start ? 11'd0 : cnt_q;
        cnt_sum  = {1'b0, cnt_base} + 12'(nbits);
        cnt_d    = cnt_base;
        if (beat_acc) cnt_d = cnt_sum[11] ? 11'h7ff : cnt_sum[10:0];

        err_free_d = err_free_q;
        len_err_d  = len_err_q;
        valid_d    = valid_q;
        pend_d     = 1'b0;
        if (i_start) begin
            err_free_d = 1'b0;
            len_err_d  = 1'b0;
            valid_d    = 1'b0;
            // A word finished in the start cycle still shows o_valid low for one cycle.
            pend_d     = done_now;
        end else if (pend_q || done_now) begin
            valid_d = 1'b1;
        end
        if (done_now) begin
            // Squares of zero are zero, so the accumulated syndromes decide this alone.
            err_free_d = (acc_step == '0);
            len_err_d  = (32'(cnt_d) > MAX_BITS);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
            err_free_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            pend_q     <= pend_d;
            err_free_q <= err_free_d;
            len_err_q  <= len_err_d;
        end
    end

`ifdef SYN_SQUARE_EN
    logic [9:0] sq2, sq4, sq6, sq8;
    assign sq2  = gf_sq(acc_q[0]);
    assign sq4  = gf_sq(sq2);
    assign sq6  = gf_sq(acc_q[1]);
    assign sq8  = gf_sq(sq4);
    assign o_S1 = acc_q[0];
    assign o_S2 = sq2;
    assign o_S3 = acc_q[1];
    assign o_S4 = sq4;
    assign o_S5 = acc_q[2];
    assign o_S6 = sq6;
    assign o_S7 = acc_q[3];
    assign o_S8 = sq8;
`else
    assign o_S1 = acc_q[0];
    assign o_S2 = acc_q[1];
    assign o_S3 = acc_q[2];
    assign o_S4 = acc_q[3];
    assign o_S5 = acc_q[4];
    assign o_S6 = acc_q[5];
    assign o_S7 = acc_q[6];
    assign o_S8 = acc_q[7];
`endif

    assign o_valid    = valid_q;
    assign o_err_free = err_free_q;
    assign o_len_err  = len_err_q;

endmodule

// File: doc/syndrome_calc.md
# syndrome_calc

- Computes the eight 10-bit BCH syndromes S1..S8 over GF(2^10) for one received codeword.
- The codeword is streamed in 8-bit beats.
- Sits directly upstream of the syndrome switch, which consumes one instance's S1..S8 and its level-held valid.
- Four instances (tp1..tp4) run in parallel in multi-codeword modes; each instance is fully independent.

## Interface
Parameters:
- MAX_BITS, 1023, largest legal codeword length in bits; longer words flag a length error.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  single-cycle pulse; clears accumulators and begins a new codeword.
- i_data  in  8  received bits, MSB-first; bit 7 is the highest remaining polynomial degree.
- i_data_valid  in  1  beat qualifier.
- i_last  in  1  marks final beat of the codeword; only meaningful with i_data_valid.
- i_last_cnt  in  3  number of valid bits on the last beat, MSB-aligned in i_data[7 -: k]; 0 means 8.
- o_S1..o_S8  out  10 each  syndromes S_j = r(alpha^j).
- o_valid  out  1  level; high from result ready until next i_start or reset.
- o_err_free  out  1  all eight syndromes zero; qualified by o_valid.
- o_len_err  out  1  bit count exceeded MAX_BITS; qualified by o_valid.
- o_busy  out  1  high while accumulating (state ACC).

## Operation
- Field: GF(2^10), primitive polynomial x^10+x^3+1.
  - alpha = 10'h002.
  - Element bit i is the coefficient of alpha^i.
  - alpha^10 = 10'h009.
- Horner update per accepted bit b: S_j <= S_j*alpha^j XOR {9'b0,b}.
  - A beat applies 8 sequential steps combinationally, in order bit 7 down to bit 0.
  - On the last beat, only the top k bits are stepped; the low 8-k bits are ignored.
- State machine:
  - IDLE: reset state; beats ignored. i_start -> ACC.
  - ACC: accept beats. Beat with i_last -> DONE.
  - DONE: outputs held; beats ignored. i_start -> ACC.
  - i_start in ACC restarts the word: accumulators cleared, stays in ACC.
- i_start with i_data_valid in the same cycle: accumulators are cleared and that beat is processed as the first beat of the new word.
- Bit counter: 11 bits, saturates at 2047. If the count exceeds MAX_BITS, o_len_err is set for the word; syndromes are still computed over all bits received.
- An empty word cannot occur; every word contains at least one beat.

## Timing
- Reset values: all o_S* = 0, o_valid=0, o_err_free=0, o_len_err=0, o_busy=0, state IDLE.
- Reset mid-word discards the word; no result is produced.
- Result latency: the last beat is accepted in cycle t; o_S*, o_err_free, o_len_err and o_valid are registered and visible in cycle t+1.
- o_valid:
  - Drops in the cycle after i_start is sampled.
  - During ACC, o_S* show partial accumulator values; downstream must qualify with o_valid.
- Throughput: one beat per cycle, no backpressure, no ready signal.
- Back-to-back words: i_start may arrive in the cycle right after the last beat; o_valid is then high for exactly one cycle.

## Configuration
- SYN_SQUARE_EN defined: only the odd syndromes S1, S3, S5, S7 are accumulated.
  - Even syndromes are derived by GF squaring networks: S2=S1^2, S4=S2^2, S6=S3^2, S8=S4^2.
  - The squaring networks are combinational from the registered odd values, so latency is unchanged.
  - Valid for binary codewords only, which is all this block receives.
- SYN_SQUARE_EN undefined: all eight syndromes are accumulated directly.
- Outputs must be bit-identical in both builds.

## Test plan
- All-zero word: start, then 128 beats of 8'h00 (last_cnt=0, 1024 bits). Required: all S=0, o_err_free=1, o_len_err=1 (1024 > 1023), o_valid rises one cycle after the last beat.
- Single-bit word: start, then one beat 8'h80 with i_last, last_cnt=1 (r(x)=1). Required: all S=10'h001, o_err_free=0, o_len_err=0.
- Two-bit word: start, then one beat 8'h80 with i_last, last_cnt=2 (r(x)=x). Required: S1..S8 = 002, 004, 008, 010, 020, 040, 080, 100 (hex).
- Eleven-bit word: two beats, 8'h80 then 8'h00 with i_last, last_cnt=3 (r(x)=x^10). Required: S1=10'h009 and S2=10'h041; repeat with SYN_SQUARE_EN and require identical values.
- i_start in the same cycle as a beat 8'h80 with i_last, last_cnt=1, taken from DONE holding a nonzero result. Required: o_valid low one cycle, then high with all S=10'h001.
- Async reset asserted mid-word. Required: all outputs 0 immediately; after release, beats are ignored until i_start, and the next full word produces correct syndromes.
